// File: rtl/aemb2_tmr_pkg.sv
// Shared definitions for the AEMB2 Wishbone timer: register map, CTRL bits,
// bus FSM encoding and the byte-lane merge helper.
package aemb2_tmr_pkg;

    localparam logic [1:0] TMR_COUNT  = 2'd0;
    localparam logic [1:0] TMR_RELOAD = 2'd1;
    localparam logic [1:0] TMR_CTRL   = 2'd2;
    localparam logic [1:0] TMR_STAT   = 2'd3;

    localparam int EN   = 0;
    localparam int AUTO = 1;
    localparam int IE   = 2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_ACK  = 2'd2
    } bus_state_e;

    // sel bit b owns bits [8b+7:8b], so sel[3] is the big-endian MSB lane
    function automatic logic [31:0] lane_merge(input logic [31:0] old_v,
                                               input logic [31:0] new_v,
                                               input logic [3:0]  sel);
        logic [31:0] res;
        for (int b = 0; b < 4; b++) begin
            res[b*8 +: 8] = sel[b] ? new_v[b*8 +: 8] : old_v[b*8 +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/aemb2_tmr_ch.sv
// One timer channel: COUNT/RELOAD/CTRL/PEND registers and the down-counter.
module aemb2_tmr_ch
    import aemb2_tmr_pkg::*;
(
    input  logic        sys_clk_i,
    input  logic        sys_rst_ni,
    input  logic        tick,
    input  logic        wr_stb,
    input  logic [3:0]  wr_sel,
    input  logic [31:0] wr_dat,
    input  logic [1:0]  reg_idx,
    output logic [31:0] count,
    output logic [31:0] reload,
    output logic [2:0]  ctrl,
    output logic        pend
);

    logic [31:0] count_r;
    logic [31:0] reload_r;
    logic [2:0]  ctrl_r;
    logic        pend_r;

    logic wr_count_s;
    logic wr_reload_s;
    logic wr_ctrl_s;
    logic w1c_s;
    logic run_s;
    logic expire_s;

    // Decode bus writes; a COUNT/CTRL write swallows the tick on that edge
    always_comb begin
        wr_count_s  = wr_stb && (reg_idx == TMR_COUNT)  && (wr_sel != 4'd0);
        wr_reload_s = wr_stb && (reg_idx == TMR_RELOAD) && (wr_sel != 4'd0);
        wr_ctrl_s   = wr_stb && (reg_idx == TMR_CTRL)   && wr_sel[0];
        w1c_s       = wr_stb && (reg_idx == TMR_STAT)   && wr_sel[0] && wr_dat[0];
        run_s       = tick && ctrl_r[EN] && !wr_count_s && !wr_ctrl_s;
        expire_s    = run_s && (count_r == 32'd0);
    end

    // Counter: bus write, else decrement, else reload on expiry; saturates at 0
    always_ff @(posedge sys_clk_i or negedge sys_rst_ni) begin
        if (!sys_rst_ni) begin
            count_r <= 32'd0;
        end else if (wr_count_s) begin
            count_r <= lane_merge(count_r, wr_dat, wr_sel);
        end else if (run_s && (count_r != 32'd0)) begin
            count_r <= count_r - 32'd1;
        end else if (expire_s && ctrl_r[AUTO]) begin
            count_r <= reload_r;
        end else begin
            count_r <= count_r;
        end
    end

    // RELOAD, CTRL (one-shot expiry drops EN) and sticky PEND with W1C
    always_ff @(posedge sys_clk_i or negedge sys_rst_ni) begin
        if (!sys_rst_ni) begin
            reload_r <= 32'd0;
            ctrl_r   <= 3'd0;
            pend_r   <= 1'b0;
        end else begin
            if (wr_reload_s) begin
                reload_r <= lane_merge(reload_r, wr_dat, wr_sel);
            end else begin
                reload_r <= reload_r;
            end
            if (wr_ctrl_s) begin
                ctrl_r <= wr_dat[2:0];
            end else if (expire_s && !ctrl_r[AUTO]) begin
                ctrl_r <= ctrl_r & 3'b110;
            end else begin
                ctrl_r <= ctrl_r;
            end
            if (expire_s) begin
                pend_r <= 1'b1;
            end else if (w1c_s) begin
                pend_r <= 1'b0;
            end else begin
                pend_r <= pend_r;
            end
        end
    end

    assign count  = count_r;
    assign reload = reload_r;
    assign ctrl   = ctrl_r;
    assign pend   = pend_r;

endmodule

// File: rtl/aemb2_tmr_wb.sv
// AEMB2 data-bus timer block: prescaler, Wishbone slave FSM with wait states,
// read mux and OR-reduced interrupt over AEMB_TMR_N channels.
module aemb2_tmr_wb
    import aemb2_tmr_pkg::*;
#(
    parameter int AEMB_TMR_N = 2,
    parameter int AEMB_PSC   = 0,
    parameter int AEMB_WAIT  = 0,
    localparam int AW        = $clog2(AEMB_TMR_N) + 2
) (
    input  logic          sys_clk_i,
    input  logic          sys_rst_ni,
    input  logic          tmr_cyc_i,
    input  logic          tmr_stb_i,
    input  logic          tmr_wre_i,
    input  logic [3:0]    tmr_sel_i,
    input  logic [AW-1:0] tmr_adr_i,
    input  logic [31:0]   tmr_dat_i,
    output logic [31:0]   tmr_dat_o,
    output logic          tmr_ack_o,
    output logic          sys_int_o
);

    localparam logic [1:0] WAIT_LOAD = (AEMB_WAIT > 0) ? 2'(AEMB_WAIT - 1) : 2'd0;

    logic        tick_s;
    logic [3:0]  ch_s;
    logic [1:0]  reg_s;
    logic        req_s;
    logic        enter_ack_s;
    logic        wr_go_s;
    logic [31:0] rd_s;

    bus_state_e  state_r;
    bus_state_e  state_nx_s;
    logic [1:0]  wait_r;
    logic [1:0]  wait_nx_s;
    logic        ack_r;
    logic [31:0] dat_r;
    logic        int_r;

    logic [31:0] ch_count_s [AEMB_TMR_N];
    logic [31:0] ch_reload_s[AEMB_TMR_N];
    logic [2:0]  ch_ctrl_s  [AEMB_TMR_N];
    logic [31:0] ch_rd_s    [AEMB_TMR_N];
    logic [AEMB_TMR_N-1:0] ch_pend_s;
    logic [AEMB_TMR_N-1:0] irq_vec_s;

    if (AEMB_PSC > 0) begin : g_psc
        logic [AEMB_PSC-1:0] psc_r;
        // Free-running prescaler; tick on its all-ones state
        always_ff @(posedge sys_clk_i or negedge sys_rst_ni) begin
            if (!sys_rst_ni) begin
                psc_r <= '0;
            end else begin
                psc_r <= psc_r + AEMB_PSC'(1);
            end
        end
        assign tick_s = &psc_r;
    end else begin : g_nopsc
        assign tick_s = 1'b1;
    end

    if (AW > 2) begin : g_chidx
        assign ch_s = 4'(tmr_adr_i[AW-1:2]);
    end else begin : g_onech
        assign ch_s = 4'd0;
    end

    assign reg_s   = tmr_adr_i[1:0];
    assign req_s   = tmr_cyc_i && tmr_stb_i;
    assign wr_go_s = enter_ack_s && tmr_wre_i;

    for (genvar i = 0; i < AEMB_TMR_N; i++) begin : g_ch
        aemb2_tmr_ch u_ch (
            .sys_clk_i  (sys_clk_i),
            .sys_rst_ni (sys_rst_ni),
            .tick       (tick_s),
            .wr_stb     (wr_go_s && (ch_s == 4'(i))),
            .wr_sel     (tmr_sel_i),
            .wr_dat     (tmr_dat_i),
            .reg_idx    (reg_s),
            .count      (ch_count_s[i]),
            .reload     (ch_reload_s[i]),
            .ctrl       (ch_ctrl_s[i]),
            .pend       (ch_pend_s[i])
        );

        assign irq_vec_s[i] = ch_pend_s[i] && ch_ctrl_s[i][IE];

        // Per-channel read value, zero unless this channel is addressed
        always_comb begin
            ch_rd_s[i] = 32'd0;
            if (ch_s == 4'(i)) begin
                case (reg_s)
                    TMR_COUNT:  ch_rd_s[i] = ch_count_s[i];
                    TMR_RELOAD: ch_rd_s[i] = ch_reload_s[i];
                    TMR_CTRL:   ch_rd_s[i] = {29'd0, ch_ctrl_s[i]};
                    TMR_STAT:   ch_rd_s[i] = {31'd0, ch_pend_s[i]};
                    default:    ch_rd_s[i] = 32'd0;
                endcase
            end else begin
                ch_rd_s[i] = 32'd0;
            end
        end
    end

    // OR the channel read values; unimplemented channels contribute zero
    always_comb begin
        rd_s = 32'd0;
        for (int i = 0; i < AEMB_TMR_N; i++) begin
            rd_s = rd_s | ch_rd_s[i];
        end
    end

    // Bus FSM next state; dropping stb before ACK aborts back to IDLE
    always_comb begin
        state_nx_s  = ST_IDLE;
        wait_nx_s   = wait_r;
        enter_ack_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (req_s && (AEMB_WAIT > 0)) begin
                    state_nx_s = ST_WAIT;
                    wait_nx_s  = WAIT_LOAD;
                end else if (req_s) begin
                    state_nx_s  = ST_ACK;
                    enter_ack_s = 1'b1;
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (!req_s) begin
                    state_nx_s = ST_IDLE;
                end else if (wait_r == 2'd0) begin
                    state_nx_s  = ST_ACK;
                    enter_ack_s = 1'b1;
                end else begin
                    state_nx_s = ST_WAIT;
                    wait_nx_s  = wait_r - 2'd1;
                end
            end
            ST_ACK:  state_nx_s = ST_IDLE;
            default: state_nx_s = ST_IDLE;
        endcase
    end

    // Bus state, registered ack/read data and interrupt
    always_ff @(posedge sys_clk_i or negedge sys_rst_ni) begin
        if (!sys_rst_ni) begin
            state_r <= ST_IDLE;
            wait_r  <= 2'd0;
            ack_r   <= 1'b0;
            dat_r   <= 32'd0;
            int_r   <= 1'b0;
        end else begin
            state_r <= state_nx_s;
            wait_r  <= wait_nx_s;
            ack_r   <= enter_ack_s;
            dat_r   <= enter_ack_s ? rd_s : 32'd0;
            int_r   <= |irq_vec_s;
        end
    end

    assign tmr_ack_o = ack_r;
    assign tmr_dat_o = dat_r;
    assign sys_int_o = int_r;

endmodule
